unpool1_backward: RTL
=====================

UNPOOL1_BACKWARD -- requirements
Module: unpool1_backward

Interface
REQ-001 Parameter CHANNELS, default 16, number of feature maps.
REQ-002 Parameter IN_DIM, default 26, forward-input height/width; output window grid is IN_DIM/2 = 13.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level request to begin one backward pass.
REQ-006 done  output  1  one-cycle completion pulse.
REQ-007 busy  output  1  high while a pass is in progress.
REQ-008 feature_maps  input  signed 32 x [0:CHANNELS-1][0:IN_DIM-1][0:IN_DIM-1]  forward-pass pool input, used for argmax recomputation.
REQ-009 grad_in  input  signed 32 x [0:CHANNELS-1][0:13][0:13]  gradient w.r.t. pooled maps; row 13 and column 13 are ignored.
REQ-010 grad_out  output  signed 32 x [0:CHANNELS-1][0:IN_DIM-1][0:IN_DIM-1]  gradient w.r.t. feature_maps.

Function
REQ-011 States SHALL be IDLE, ROUTE, DONE, WAIT_START_LOW.
REQ-012 IDLE -> ROUTE when start=1 at a clock edge; otherwise stay in IDLE.
REQ-013 ROUTE processes exactly one 2x2 window per cycle, order f outer, i middle, j inner, each over 0..CHANNELS-1, 0..12, 0..12.
REQ-014 ROUTE -> DONE on the cycle that processes f=CHANNELS-1, i=12, j=12; ROUTE lasts exactly CHANNELS*169 cycles (2704 at default).
REQ-015 DONE -> WAIT_START_LOW unconditionally after one cycle; WAIT_START_LOW -> IDLE when start=0.
REQ-016 Window (f,i,j) covers feature_maps[f][2i..2i+1][2j..2j+1]; argmax uses order TL, TR, BL, BR with strict signed greater-than, so ties go to the earliest position in that order.
REQ-017 Per window: grad_out at argmax position <= grad_in[f][i][j], unmodified. The other three positions <= 0 in the same cycle.
REQ-018 Every grad_out element is written exactly once per pass, so no separate clear phase is needed.
REQ-019 Comparisons are 32-bit signed; no saturation or width change on the routed value.
REQ-020 done is registered: high for exactly the one cycle the FSM is in DONE, low otherwise.
REQ-021 busy is high in ROUTE and DONE, low in IDLE and WAIT_START_LOW.
REQ-022 start is ignored in ROUTE and DONE. Holding start high after completion does not relaunch; a new pass needs start low, then high again.
REQ-023 feature_maps and grad_in must stay stable from the start edge until done; output is undefined otherwise.
REQ-024 Window counters reset to 0 on entry to ROUTE from IDLE.

Reset
REQ-025 reset=1 forces state=IDLE, done=0, busy=0 and f=i=j=0 asynchronously.
REQ-026 grad_out is not reset; it holds its last written values. After reset mid-pass its contents are partially updated and undefined until the next complete pass.
REQ-027 After reset deasserts with start=1, the next clock edge enters ROUTE (start is level-sensitive in IDLE).

Verification
REQ-028 Single max: feature_maps[0][0..1][0..1]={1,5,2,3}, grad_in[0][0][0]=7 -> grad_out[0][0][1]=7 and grad_out[0][0][0], [1][0], [1][1] = 0.
REQ-029 Tie and negatives: window all -4, grad_in=-9 -> only TL = -9. Window {-8,-2,-2,-3} -> TR = grad_in, others 0.
REQ-030 Timing: start pulsed at edge T -> busy high from T+1, done high exactly at edge T+2705 (one cycle), busy low after; start held high afterward gives no second done.
REQ-031 Full random pass: compare all 16x26x26 grad_out entries against a software reference max-pool backward; grad_in row/col 13 = 0x7FFFFFFF never appears in output.
REQ-032 Reset mid-pass at cycle 1000: state IDLE, done=0, busy=0 immediately; a following start gives a full correct pass with done after 2704 ROUTE cycles.
REQ-033 Back-to-back: two passes with different grad_in, start dropped for one cycle between them -> second result fully overwrites the first.

Source files
------------

// File: rtl/unpool1_backward.sv
// 2x2 max-unpool backward pass.
// One 2x2 window is handled per cycle. For each window the argmax is
// recomputed from the forward-pass input. The incoming gradient is routed
// to that position, and the other three positions of the window get zero.
// Every output element lies in exactly one window, so a full pass rewrites
// the whole gradient map and no clear phase is needed.

// Argmax of one 2x2 window.
// Positions are scanned in the order TL, TR, BL, BR using a strict
// signed greater-than, so a tie stays with the earliest position.
module unpool1_argmax (
  input  logic signed [31:0] tl,
  input  logic signed [31:0] tr,
  input  logic signed [31:0] bl,
  input  logic signed [31:0] br,
  output logic        [1:0]  sel
);

  logic signed [31:0] best;

  // Running maximum over the scan order. Only a strictly larger value
  // replaces the current best.
  always_comb begin
    sel  = 2'd0;
    best = tl;
    if (tr > best) begin
      sel  = 2'd1;
      best = tr;
    end
    if (bl > best) begin
      sel  = 2'd2;
      best = bl;
    end
    if (br > best) begin
      sel  = 2'd3;
      best = br;
    end
  end

endmodule

// Top level: window sequencer, gradient router and output storage.
module unpool1_backward #(
  parameter int CHANNELS = 16,
  parameter int IN_DIM   = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               done,
  output logic               busy,
  input  logic signed [31:0] feature_maps [0:CHANNELS-1][0:IN_DIM-1][0:IN_DIM-1],
  input  logic signed [31:0] grad_in      [0:CHANNELS-1][0:IN_DIM/2][0:IN_DIM/2],
  output logic signed [31:0] grad_out     [0:CHANNELS-1][0:IN_DIM-1][0:IN_DIM-1]
);

  localparam int OUT_DIM = IN_DIM / 2;
  localparam int FW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  localparam logic [FW-1:0] F_LAST = FW'(CHANNELS - 1);
  localparam logic [DW-1:0] D_LAST = DW'(OUT_DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ROUTE      = 2'd1,
    S_DONE       = 2'd2,
    S_WAIT_START = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   f_q, f_d;
  logic [DW-1:0]   i_q, i_d;
  logic [DW-1:0]   j_q, j_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;
  logic            last_win;

  // Window geometry. Each window covers rows 2i..2i+1 and columns 2j..2j+1.
  logic [DW:0]     r0, r1, c0, c1;
  logic signed [31:0] win_tl, win_tr, win_bl, win_br, win_g;
  logic [1:0]      sel;
  logic signed [31:0] wr_tl_d, wr_tr_d, wr_bl_d, wr_br_d;
  logic            route_en;

  // Gradient storage. It is deliberately not reset; it holds the last
  // written values.
  logic signed [31:0] grad_out_q [0:CHANNELS-1][0:IN_DIM-1][0:IN_DIM-1];

  assign last_win = (f_q == F_LAST) && (i_q == D_LAST) && (j_q == D_LAST);
  assign route_en = (state_q == S_ROUTE);

  assign r0 = {i_q, 1'b0};
  assign r1 = {i_q, 1'b1};
  assign c0 = {j_q, 1'b0};
  assign c1 = {j_q, 1'b1};

  assign win_tl = feature_maps[f_q][r0][c0];
  assign win_tr = feature_maps[f_q][r0][c1];
  assign win_bl = feature_maps[f_q][r1][c0];
  assign win_br = feature_maps[f_q][r1][c1];
  assign win_g  = grad_in[f_q][i_q][j_q];

  unpool1_argmax u_argmax (
    .tl  (win_tl),
    .tr  (win_tr),
    .bl  (win_bl),
    .br  (win_br),
    .sel (sel)
  );

  // State register, window counters and registered status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      i_q     <= i_d;
      j_q     <= j_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. Start is level-sensitive in IDLE. A new pass needs
  // start to drop after a completed pass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start)    state_d = S_ROUTE;
      S_ROUTE:      if (last_win) state_d = S_DONE;
      S_DONE:                     state_d = S_WAIT_START;
      S_WAIT_START: if (!start)   state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // Window counter sequencing: f outer, i middle, j inner.
  // The counters are held at zero outside ROUTE, so every pass starts at window 0.
  always_comb begin
    f_d = f_q;
    i_d = i_q;
    j_d = j_q;
    if (state_q != S_ROUTE || last_win) begin
      f_d = '0;
      i_d = '0;
      j_d = '0;
    end else if (j_q != D_LAST) begin
      j_d = j_q + 1'b1;
    end else begin
      j_d = '0;
      if (i_q != D_LAST) begin
        i_d = i_q + 1'b1;
      end else begin
        i_d = '0;
        f_d = f_q + 1'b1;
      end
    end
  end

  // Output decode from the next state, so done and busy are flop outputs
  // aligned with the state they describe.
  always_comb begin
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_ROUTE) || (state_d == S_DONE);
  end

  // Route the gradient to the argmax position and zero the other three.
  always_comb begin
    wr_tl_d = (sel == 2'd0) ? win_g : 32'sd0;
    wr_tr_d = (sel == 2'd1) ? win_g : 32'sd0;
    wr_bl_d = (sel == 2'd2) ? win_g : 32'sd0;
    wr_br_d = (sel == 2'd3) ? win_g : 32'sd0;
  end

  // Write all four window positions in the cycle the window is routed.
  always_ff @(posedge clk) begin
    if (route_en) begin
      grad_out_q[f_q][r0][c0] <= wr_tl_d;
      grad_out_q[f_q][r0][c1] <= wr_tr_d;
      grad_out_q[f_q][r1][c0] <= wr_bl_d;
      grad_out_q[f_q][r1][c1] <= wr_br_d;
    end
  end

  assign grad_out = grad_out_q;
  assign done     = done_q;
  assign busy     = busy_q;

endmodule
